ex_alu_stage: RTL and testbench

//  Execute stage that consumes the decoded {alucontrol, shift} pair plus operands from decode.

---
 rtl/ex_alu_stage.sv | 123 ++++++++++++
 tb/tb_ex_alu_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_alu_stage.sv
// Execute stage: ID/EX register, ALU datapath and EX/MEM result register.
// Stall and flush from the hazard unit control which slots advance or turn into bubbles.
module ex_alu_stage #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int REG_W   = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [2:0]         id_alucontrol,
   input  logic               id_shift,
   input  logic [SHAMT_W-1:0] id_shamt,
   input  logic [WIDTH-1:0]   id_srca,
   input  logic [WIDTH-1:0]   id_srcb,
   input  logic [REG_W-1:0]   id_writereg,
   input  logic               id_regwrite,
   output logic               ex_valid,
   output logic [WIDTH-1:0]   ex_aluout,
   output logic               ex_zero,
   output logic               ex_ovf,
   output logic [REG_W-1:0]   ex_writereg,
   output logic               ex_regwrite
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic               idex_valid;
   logic [2:0]         idex_alucontrol;
   logic               idex_shift;
   logic [SHAMT_W-1:0] idex_shamt;
   logic [WIDTH-1:0]   idex_srca;
   logic [WIDTH-1:0]   idex_srcb;
   logic [REG_W-1:0]   idex_writereg;
   logic               idex_regwrite;

   // Hazard control: flush squashes the ID/EX slot (and beats stall); stall freezes
   // ID/EX and pushes a bubble into EX/MEM so nothing is issued twice.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         idex_valid      <= 1'b0;
         idex_alucontrol <= '0;
         idex_shift      <= 1'b0;
         idex_shamt      <= '0;
         idex_srca       <= '0;
         idex_srcb       <= '0;
         idex_writereg   <= '0;
         idex_regwrite   <= 1'b0;
      end else if (!stall) begin
         idex_valid      <= id_valid;
         idex_alucontrol <= id_alucontrol;
         idex_shift      <= id_shift;
         idex_shamt      <= id_shamt;
         idex_srca       <= id_srca;
         idex_srcb       <= id_srcb;
         idex_writereg   <= id_writereg;
         idex_regwrite   <= id_regwrite & id_valid;
      end
   end

   logic [SHAMT_W-1:0] sa;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   result;
   logic               ovf;

   assign sa   = idex_shift ? idex_shamt : idex_srca[SHAMT_W-1:0];
   assign sum  = idex_srca + idex_srcb;
   assign diff = idex_srca - idex_srcb;

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (idex_alucontrol)
         OP_ADD: begin
            result = sum;
            ovf    = (idex_srca[WIDTH-1] == idex_srcb[WIDTH-1]) &&
                     (sum[WIDTH-1] != idex_srca[WIDTH-1]);
         end
         OP_SUB: begin
            result = diff;
            ovf    = (idex_srca[WIDTH-1] != idex_srcb[WIDTH-1]) &&
                     (diff[WIDTH-1] != idex_srca[WIDTH-1]);
         end
         OP_AND: result = idex_srca & idex_srcb;
         OP_OR:  result = idex_srca | idex_srcb;
         OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(idex_srca) < $signed(idex_srcb))};
         OP_SLL: result = idex_srcb << sa;
         OP_SRL: result = idex_srcb >> sa;
         OP_SRA: result = $unsigned($signed(idex_srcb) >>> sa);
         default: result = '0;
      endcase
   end

   // Bubbles leave EX/MEM fully cleared so no stale result is visible downstream.
   always_ff @(posedge clk) begin
      if (reset || stall || !idex_valid) begin
         ex_valid    <= 1'b0;
         ex_aluout   <= '0;
         ex_zero     <= 1'b0;
         ex_ovf      <= 1'b0;
         ex_writereg <= '0;
         ex_regwrite <= 1'b0;
      end else begin
         ex_valid    <= 1'b1;
         ex_aluout   <= result;
         ex_zero     <= (result == '0);
         ex_ovf      <= ovf;
         ex_writereg <= idex_writereg;
         ex_regwrite <= idex_regwrite;
      end
   end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed cases plus random traffic against an arithmetic
// reference model of the two-register pipeline.
module tb_ex_alu_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        id_valid = 1'b0;
   logic [2:0]  id_alucontrol = 3'b000;
   logic        id_shift = 1'b0;
   logic [4:0]  id_shamt = 5'd0;
   logic [31:0] id_srca = 32'd0;
   logic [31:0] id_srcb = 32'd0;
   logic [4:0]  id_writereg = 5'd0;
   logic        id_regwrite = 1'b0;
   logic        ex_valid;
   logic [31:0] ex_aluout;
   logic        ex_zero;
   logic        ex_ovf;
   logic [4:0]  ex_writereg;
   logic        ex_regwrite;

   int total = 0;
   int bad   = 0;

   // clock / reset
   always #5 clk = ~clk;

   ex_alu_stage #(.WIDTH(32), .SHAMT_W(5), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_alucontrol(id_alucontrol), .id_shift(id_shift),
      .id_shamt(id_shamt), .id_srca(id_srca), .id_srcb(id_srcb),
      .id_writereg(id_writereg), .id_regwrite(id_regwrite),
      .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_zero(ex_zero), .ex_ovf(ex_ovf),
      .ex_writereg(ex_writereg), .ex_regwrite(ex_regwrite)
   );

   // reference model: instruction waiting to execute, and the expected EX/MEM outputs
   logic        m_valid = 1'b0, m_shift = 1'b0, m_rw = 1'b0;
   logic [2:0]  m_ctl = 3'd0;
   logic [4:0]  m_shamt = 5'd0, m_rd = 5'd0;
   logic [31:0] m_a = 32'd0, m_b = 32'd0;
   logic        e_valid = 1'b0, e_zero = 1'b0, e_ovf = 1'b0, e_rw = 1'b0;
   logic [4:0]  e_rd = 5'd0;
   logic [31:0] exp_q[$];

   function automatic void alu_ref(input logic [2:0] ctl, input logic sh, input logic [4:0] shamt,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic ovf);
      int     amt;
      longint sa_l, sb_l, s;
      amt  = sh ? int'(shamt) : int'(a % 32);
      sa_l = longint'($signed(a));
      sb_l = longint'($signed(b));
      res  = 32'd0;
      ovf  = 1'b0;
      s    = 0;
      case (ctl)
         3'b010: begin s = sa_l + sb_l; res = s[31:0]; ovf = (s != longint'($signed(res))); end
         3'b110: begin s = sa_l - sb_l; res = s[31:0]; ovf = (s != longint'($signed(res))); end
         3'b000: res = a & b;
         3'b001: res = a | b;
         3'b111: res = (sa_l < sb_l) ? 32'd1 : 32'd0;
         3'b011: begin s = longint'({32'd0, b}) * (64'sd1 << amt); res = s[31:0]; end
         3'b101: begin s = longint'({32'd0, b}) / (64'sd1 << amt); res = s[31:0]; end
         default: begin s = sb_l >>> amt; res = s[31:0]; end
      endcase
   endfunction

   // advance the model by one clock edge using the inputs currently applied
   task automatic model_edge();
      logic [31:0] r;
      logic        o;
      if (reset) begin
         m_valid = 1'b0; m_rw = 1'b0;
         e_valid = 1'b0; e_zero = 1'b0; e_ovf = 1'b0; e_rw = 1'b0; e_rd = 5'd0;
         exp_q.delete();
      end else begin
         if (stall || !m_valid) begin
            e_valid = 1'b0; e_zero = 1'b0; e_ovf = 1'b0; e_rw = 1'b0; e_rd = 5'd0;
         end else begin
            alu_ref(m_ctl, m_shift, m_shamt, m_a, m_b, r, o);
            e_valid = 1'b1; e_zero = (r == 32'd0); e_ovf = o; e_rw = m_rw; e_rd = m_rd;
            exp_q.push_back(r);
         end
         if (flush) begin
            m_valid = 1'b0; m_rw = 1'b0;
         end else if (!stall) begin
            m_valid = id_valid; m_ctl = id_alucontrol; m_shift = id_shift; m_shamt = id_shamt;
            m_a = id_srca; m_b = id_srcb; m_rd = id_writereg; m_rw = id_regwrite && id_valid;
         end
      end
   endtask

   // scoreboard
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("valid", 32'(ex_valid), 32'(e_valid));
      chk("regwrite", 32'(ex_regwrite), 32'(e_rw));
      chk("zero", 32'(ex_zero), 32'(e_zero));
      chk("ovf", 32'(ex_ovf), 32'(e_ovf));
      if (e_valid) begin
         chk("writereg", 32'(ex_writereg), 32'(e_rd));
         if (exp_q.size() > 0) chk("aluout", ex_aluout, exp_q.pop_front());
      end else begin
         chk("aluout_bubble", ex_aluout, 32'd0);
      end
   endtask

   // driver tasks
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic drive_op(input logic [2:0] ctl, input logic sh, input logic [4:0] shamt,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic rw);
      id_valid = 1'b1; id_alucontrol = ctl; id_shift = sh; id_shamt = shamt;
      id_srca = a; id_srcb = b; id_writereg = rd; id_regwrite = rw;
   endtask

   task automatic drive_idle();
      id_valid = 1'b0; id_regwrite = 1'b0;
   endtask

   initial begin
      int cnt;
      logic [31:0] pick [0:5];
      pick[0] = 32'h0000_0000; pick[1] = 32'h7FFF_FFFF; pick[2] = 32'h8000_0000;
      pick[3] = 32'hFFFF_FFFF; pick[4] = 32'h0000_0001; pick[5] = 32'h8000_0010;

      // reset: first edge clears everything
      reset = 1'b1; stall = 1'b1; flush = 1'b1;
      drive_op(3'b010, 1'b0, 5'd0, 32'd1, 32'd1, 5'd9, 1'b1);
      step();
      chk("reset_valid", 32'(ex_valid), 32'd0);
      chk("reset_aluout", ex_aluout, 32'd0);
      chk("reset_writereg", 32'(ex_writereg), 32'd0);
      stall = 1'b0; flush = 1'b0; drive_idle();
      step();
      reset = 1'b0;

      // add with signed overflow, two-cycle latency
      drive_op(3'b010, 1'b0, 5'd0, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1);
      step();
      chk("add_latency_valid", 32'(ex_valid), 32'd0);
      drive_idle();
      step();
      chk("add_ovf_aluout", ex_aluout, 32'h8000_0000);
      chk("add_ovf_flag", 32'(ex_ovf), 32'd1);
      chk("add_ovf_zero", 32'(ex_zero), 32'd0);
      chk("add_ovf_rd", 32'(ex_writereg), 32'd3);

      // sub then or back to back
      drive_op(3'b110, 1'b0, 5'd0, 32'd5, 32'd5, 5'd4, 1'b1);
      step();
      drive_op(3'b001, 1'b0, 5'd0, 32'hF0, 32'h0F, 5'd5, 1'b1);
      step();
      chk("sub_zero_out", ex_aluout, 32'd0);
      chk("sub_zero_flag", 32'(ex_zero), 32'd1);
      drive_op(3'b100, 1'b1, 5'd4, 32'd0, 32'h8000_0010, 5'd6, 1'b1);
      step();
      chk("or_out", ex_aluout, 32'hFF);
      chk("or_zero", 32'(ex_zero), 32'd0);
      drive_op(3'b101, 1'b0, 5'd0, 32'h24, 32'h8000_0010, 5'd6, 1'b1);
      step();
      chk("sra_out", ex_aluout, 32'hF800_0001);
      drive_op(3'b111, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b1);
      step();
      chk("srlv_out", ex_aluout, 32'h0800_0001);
      drive_op(3'b111, 1'b0, 5'd0, 32'd1, 32'hFFFF_FFFF, 5'd7, 1'b1);
      step();
      chk("slt_neg_out", ex_aluout, 32'd1);
      chk("slt_neg_ovf", 32'(ex_ovf), 32'd0);
      drive_idle();
      step();
      chk("slt_pos_out", ex_aluout, 32'd0);
      chk("slt_pos_ovf", 32'(ex_ovf), 32'd0);

      // stall held three cycles around a valid add
      drive_op(3'b010, 1'b0, 5'd0, 32'd10, 32'd20, 5'd8, 1'b1);
      step();
      drive_idle();
      stall = 1'b1;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (ex_valid) cnt++;
      end
      stall = 1'b0;
      step();
      if (ex_valid) cnt++;
      chk("stall_emerge_out", ex_aluout, 32'd30);
      step();
      if (ex_valid) cnt++;
      chk("stall_emerge_count", 32'(cnt), 32'd1);

      // flush and stall together, then reset mid-stream
      drive_op(3'b001, 1'b0, 5'd0, 32'd1, 32'd2, 5'd10, 1'b1);
      step();
      stall = 1'b1; flush = 1'b1;
      step();
      chk("flush_stall_valid", 32'(ex_valid), 32'd0);
      stall = 1'b0; flush = 1'b0;
      step();
      chk("flush_bubble_valid", 32'(ex_valid), 32'd0);
      drive_op(3'b010, 1'b0, 5'd0, 32'd3, 32'd4, 5'd11, 1'b1);
      step();
      reset = 1'b1;
      step();
      chk("midreset_valid", 32'(ex_valid), 32'd0);
      chk("midreset_regwrite", 32'(ex_regwrite), 32'd0);
      step();
      chk("midreset_aluout", ex_aluout, 32'd0);
      reset = 1'b0;
      drive_op(3'b010, 1'b0, 5'd0, 32'd1, 32'd1, 5'd12, 1'b1);
      id_valid = 1'b0;
      step();
      step();
      chk("invalid_regwrite", 32'(ex_regwrite), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         stall = ($urandom_range(0, 6) == 0);
         flush = ($urandom_range(0, 9) == 0);
         drive_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 5)] : $urandom(),
                  ($urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 5)] : $urandom(),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         id_valid = ($urandom_range(0, 4) != 0);
         step();
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0; drive_idle();
      step();
      step();
      chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
